// File: rtl/alu_uart_ctrl.sv
// alu_uart_ctrl: sequencer between a byte UART and a combinational ALU.
// Collects operand A, operand B and opcode bytes, presents them to the ALU,
// captures the result and hands it to the UART transmitter. A per-byte
// timeout aborts a partially received command.
//
// Handshake: i_rx_done is a one-cycle valid strobe for i_rx_data with no
// back-pressure (a byte arriving while a result is in flight is dropped and
// flagged on o_error). o_tx_start is a one-cycle request that is only issued
// when i_tx_busy is low; i_tx_done closes the transmit and returns to idle.
module alu_uart_ctrl #(
  parameter int NB_DATA        = 8,
  parameter int NB_OPERADOR    = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_rx_done,
  input  logic [NB_DATA-1:0]     i_rx_data,
  input  logic                   i_tx_busy,
  input  logic                   i_tx_done,
  output logic                   o_tx_start,
  output logic [NB_DATA-1:0]     o_tx_data,
  output logic [NB_DATA-1:0]     o_dato_a,
  output logic [NB_DATA-1:0]     o_dato_b,
  output logic [NB_OPERADOR-1:0] o_operador,
  input  logic [NB_DATA-1:0]     i_resultado,
  output logic                   o_ready,
  output logic                   o_error,
  output logic [2:0]             o_state
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_A    = 3'd0,
    ST_B    = 3'd1,
    ST_OP   = 3'd2,
    ST_EXEC = 3'd3,
    ST_SEND = 3'd4,
    ST_WAIT = 3'd5
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             timeout;
  logic             receiving;
  logic             busy_phase;
  logic             tx_start_d;
  logic             error_d;
  logic             ready_d;

  // Inter-byte timer only runs while a command is partially received.
  assign receiving  = (state == ST_B) || (state == ST_OP);
  assign busy_phase = (state == ST_EXEC) || (state == ST_SEND) || (state == ST_WAIT);
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign timeout    = receiving && !i_rx_done && (cnt == CNT_LAST);

  assign o_state = state;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_A;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_A:    if (i_rx_done) next_state = ST_B;
      ST_B: begin
        if (i_rx_done)    next_state = ST_OP;
        else if (timeout) next_state = ST_A;
      end
      ST_OP: begin
        if (i_rx_done)    next_state = ST_EXEC;
        else if (timeout) next_state = ST_A;
      end
      ST_EXEC: next_state = ST_SEND;
      // Leave once the start pulse has been presented for its single cycle.
      ST_SEND: if (o_tx_start) next_state = ST_WAIT;
      ST_WAIT: if (i_tx_done)  next_state = ST_A;
      default: next_state = ST_A;
    endcase
  end

  // Output decode, registered below so no input reaches an output combinationally.
  always_comb begin
    tx_start_d = 1'b0;
    error_d    = 1'b0;
    ready_d    = 1'b0;
    // The start pulse is scheduled from EXEC so it lands in the first SEND
    // cycle when the transmitter is free; otherwise SEND retries each cycle.
    if (!i_tx_busy) begin
      if (state == ST_EXEC) tx_start_d = 1'b1;
      if ((state == ST_SEND) && !o_tx_start) tx_start_d = 1'b1;
    end
    error_d = timeout || (i_rx_done && busy_phase);
    ready_d = (next_state == ST_A);
  end

  // Registered control outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tx_start <= 1'b0;
      o_error    <= 1'b0;
      o_ready    <= 1'b0;
    end else begin
      o_tx_start <= tx_start_d;
      o_error    <= error_d;
      o_ready    <= ready_d;
    end
  end

  // Operand/opcode capture, result capture and inter-byte timer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dato_a   <= '0;
      o_dato_b   <= '0;
      o_operador <= '0;
      o_tx_data  <= '0;
      cnt        <= '0;
    end else begin
      if ((state == ST_A) && i_rx_done)  o_dato_a   <= i_rx_data;
      if ((state == ST_B) && i_rx_done)  o_dato_b   <= i_rx_data;
      if ((state == ST_OP) && i_rx_done) o_operador <= i_rx_data[NB_OPERADOR-1:0];
      // ALU has settled on the new operands by the EXEC cycle.
      if (state == ST_EXEC)              o_tx_data  <= i_resultado;
      if (receiving && !i_rx_done && !timeout) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Testbench for alu_uart_ctrl: directed and random byte streams, a small ALU
// in the environment, and a scoreboard of expected results and tx cycles.
module tb_alu_uart_ctrl;

  localparam int TIMEOUT = 20;

  logic       clk;
  logic       rst_n;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [7:0] dato_a;
  logic [7:0] dato_b;
  logic [5:0] operador;
  logic [7:0] resultado;
  logic       ready;
  logic       error;
  logic [2:0] state_dbg;

  logic       force_busy;
  logic       resp_busy;

  int         cyc;
  int         checks;
  int         errors;
  int         err_seen;
  int         err_exp;
  int         tx_seen;
  logic       prev_start;

  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];
  logic [7:0] pend[$];

  alu_uart_ctrl #(
    .NB_DATA(8),
    .NB_OPERADOR(6),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_rx_done(rx_done),
    .i_rx_data(rx_data),
    .i_tx_busy(tx_busy),
    .i_tx_done(tx_done),
    .o_tx_start(tx_start),
    .o_tx_data(tx_data),
    .o_dato_a(dato_a),
    .o_dato_b(dato_b),
    .o_operador(operador),
    .i_resultado(resultado),
    .o_ready(ready),
    .o_error(error),
    .o_state(state_dbg)
  );

  // Reference ALU: MIPS-style function codes, unknown codes give zero.
  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    logic [7:0] r;
    case (op)
      6'h20: r = a + b;
      6'h22: r = a - b;
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h03: r = $signed(a) >>> b;
      6'h02: r = a >> b;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign resultado = alu(dato_a, dato_b, operador);
  assign tx_busy   = force_busy | resp_busy;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (error) err_seen++;
      if (tx_start) begin
        check("tx_start_single", {31'd0, prev_start}, 32'd0);
        if (exp_q.size() == 0) begin
          check("tx_unexpected", 32'd1, 32'd0);
        end else begin
          check("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
          check("tx_cycle", cyc, exp_cyc_q.pop_front());
        end
        tx_seen++;
      end
      prev_start = tx_start;
    end else begin
      prev_start = 1'b0;
    end
  end

  // Transmitter model: busy for a few cycles after each start, then done.
  initial begin
    resp_busy = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_start) begin
        resp_busy = 1'b1;
        repeat (6) @(negedge clk);
        tx_done   = 1'b1;
        resp_busy = 1'b0;
        @(negedge clk);
        tx_done   = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Issue one byte after 'gap' idle cycles. The model applies the protocol
  // rules: a gap of TIMEOUT or more abandons a partial command; the third
  // byte of a command yields a result sent on the first cycle after the
  // opcode at which the transmitter is free.
  task automatic issue(input logic [7:0] b, input int gap, input int busy_hold,
                       input bit extra_exec, input bit extra_wait);
    logic [7:0] a_v;
    logic [7:0] b_v;
    logic [7:0] op_v;
    int         n;
    int         seen0;
    if (pend.size() > 0 && gap >= TIMEOUT) begin
      err_exp++;
      pend.delete();
    end
    pend.push_back(b);
    if (pend.size() == 3 && busy_hold > 0) force_busy = 1'b1;
    repeat (gap) @(negedge clk);
    pulse(b);
    if (pend.size() == 3) begin
      a_v  = pend[0];
      b_v  = pend[1];
      op_v = pend[2];
      pend.delete();
      exp_q.push_back(alu(a_v, b_v, op_v[5:0]));
      exp_cyc_q.push_back((busy_hold > 0) ? cyc + busy_hold + 1 : cyc + 1);
      seen0 = tx_seen;
      n = 0;
      if (extra_exec) begin
        err_exp++;
        pulse(8'($urandom_range(0, 255)));
        n = 1;
      end
      if (busy_hold > 0) begin
        repeat (busy_hold - n) @(negedge clk);
        force_busy = 1'b0;
      end
      if (extra_wait) begin
        n = 0;
        while (tx_seen == seen0 && n < 200) begin
          @(negedge clk);
          n++;
        end
        if (tx_seen == seen0) check("tx_wait_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
        err_exp++;
        pulse(8'($urandom_range(0, 255)));
      end
      wait_ready();
      check("error_count", err_seen, err_exp);
      check("queue_drained", exp_q.size(), 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] ops[8];
    logic [7:0] opb;
    int         r;
    int         gap;
    int         k;
    ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
    cyc = 0; checks = 0; errors = 0; err_seen = 0; err_exp = 0; tx_seen = 0;
    prev_start = 1'b0;
    rst_n = 1'b0; rx_done = 1'b0; rx_data = 8'h00; force_busy = 1'b0;

    #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_outputs", {tx_start, error, tx_data, dato_a, dato_b, operador}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'd0, ready}, 32'd1);

    // Arithmetic and shift examples.
    issue(8'h05, 1, 0, 0, 0);
    issue(8'h03, 0, 0, 0, 0);
    issue(8'h20, 0, 0, 0, 0);
    check("add_tx_data_held", {24'd0, tx_data}, 32'h08);
    issue(8'h03, 1, 0, 0, 0);
    issue(8'h05, 1, 0, 0, 0);
    issue(8'h22, 1, 0, 0, 0);
    // Transmitter busy for 10 cycles when the result is ready.
    issue(8'h80, 1, 0, 0, 0);
    issue(8'h01, 1, 0, 0, 0);
    issue(8'h03, 1, 10, 0, 0);
    // Extra byte while waiting for tx_done.
    issue(8'h80, 1, 0, 0, 0);
    issue(8'h01, 1, 0, 0, 0);
    issue(8'h02, 1, 0, 0, 1);
    check("wait_extra_tx_data", {24'd0, tx_data}, 32'h40);

    // Lone operand A followed by silence.
    issue(8'h11, 1, 0, 0, 0);
    repeat (TIMEOUT + 2) @(negedge clk);
    err_exp++;
    pend.delete();
    check("timeout_error", err_seen, err_exp);
    check("timeout_ready", {31'd0, ready}, 32'd1);
    check("timeout_keeps_a", {24'd0, dato_a}, 32'h11);
    issue(8'h07, 0, 0, 0, 0);
    issue(8'h02, 0, 0, 0, 0);
    issue(8'h24, 0, 0, 0, 0);
    // Byte on the expiry cycle is accepted; one cycle later is too late.
    issue(8'h09, 1, 0, 0, 0);
    issue(8'h06, TIMEOUT - 1, 0, 0, 0);
    issue(8'h26, TIMEOUT - 1, 0, 0, 0);
    issue(8'h33, 1, 0, 0, 0);
    issue(8'h44, TIMEOUT, 0, 0, 0);
    issue(8'h01, 0, 0, 0, 0);
    issue(8'h20, 0, 0, 0, 0);
    // Extra byte during EXEC.
    issue(8'h0F, 1, 0, 0, 0);
    issue(8'hF0, 1, 0, 0, 0);
    issue(8'hE5, 1, 0, 1, 0);

    // Reset while the opcode is awaited.
    issue(8'h21, 1, 0, 0, 0);
    issue(8'h22, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'd0, ready}, 32'd0);
    check("midrst_outputs", {tx_start, error, tx_data, dato_a, dato_b, operador}, 32'd0);
    pend.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready_release", {31'd0, ready}, 32'd1);
    issue(8'h44, 1, 0, 0, 0);
    check("midrst_loads_a", {24'd0, dato_a}, 32'h44);
    check("midrst_not_ready", {31'd0, ready}, 32'd0);
    issue(8'h10, 1, 0, 0, 0);
    issue(8'h20, 1, 0, 0, 0);

    // Random byte stream.
    for (int i = 0; i < 90; i++) begin
      r = $urandom_range(0, 15);
      if (r < 12)      gap = $urandom_range(0, 3);
      else if (r < 14) gap = TIMEOUT - 1;
      else             gap = TIMEOUT + $urandom_range(0, 2);
      if (pend.size() == 2 && gap < TIMEOUT) begin
        k   = $urandom_range(0, 8);
        opb = 8'($urandom_range(0, 255));
        if (k < 8) opb[5:0] = ops[k];
        r = $urandom_range(0, 2);
        issue(opb, gap, (r == 0) ? $urandom_range(1, 6) : 0,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        issue(8'($urandom_range(0, 255)), gap, 0, 0, 0);
      end
    end
    repeat (TIMEOUT + 2) @(negedge clk);
    if (pend.size() > 0) err_exp++;
    pend.delete();

    check("final_error_count", err_seen, err_exp);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
